// File: rtl/lr_loader.sv
// lr_loader: packs an 8-bit byte stream into 32-bit RAM words.
// A load starts from a word address and runs for a byte count. Bytes fill the
// lanes of a word in order, and each completed or final partial word is written
// out with a per-lane write-enable strobe. Writes run at one byte per cycle,
// with no stall at word boundaries.
module lr_loader #(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] start_addr,
   input  logic [14:0] byte_len,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [11:0] ram_waddr,
   output logic [31:0] ram_wdata,
   output logic [3:0]  ram_we,
   output logic        busy,
   output logic        done,
   output logic        wrap
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // Load bookkeeping
   logic [14:0] remaining;
   logic [11:0] word_addr;
   logic [1:0]  lane;

   // Partial-word assembly
   logic [31:0] asm_data;
   logic [3:0]  asm_en;

   // Per-cycle decode
   logic        start_ok;
   logic        accept;
   logic        word_last;
   logic [1:0]  phys_lane;
   logic [31:0] merged_data;
   logic [3:0]  merged_en;

   // Logical lane (arrival order within a word) to physical byte lane.
   function automatic logic [1:0] map_lane(input logic [1:0] l);
      if (BIG_ENDIAN) begin
         return 2'd3 - l;
      end
      return l;
   endfunction

   // Position a byte in its physical lane of a 32-bit word.
   function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [1:0] pl);
      return {24'd0, b} << {pl, 3'b000};
   endfunction

   // Enable bit of one physical lane.
   function automatic logic [3:0] lane_bit(input logic [1:0] pl);
      return 4'b0001 << pl;
   endfunction

   assign start_ok    = (state == IDLE) && start;
   assign accept      = in_valid && in_ready;
   assign word_last   = (lane == 2'd3) || (remaining == 15'd1);
   assign phys_lane   = map_lane(lane);
   assign merged_data = asm_data | place_byte(in_data, phys_lane);
   assign merged_en   = asm_en | lane_bit(phys_lane);

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state. LOAD with nothing left to receive is the final strobe cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (byte_len != 15'd0) ? LOAD : DONE;
            end
         end
         LOAD: begin
            if (remaining == 15'd0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         LOAD: begin
            busy     = 1'b1;
            in_ready = (remaining != 15'd0);
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   // Remaining byte count and lane counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         remaining <= 15'd0;
         lane      <= 2'd0;
      end else if (start_ok) begin
         remaining <= byte_len;
         lane      <= 2'd0;
      end else if (accept) begin
         remaining <= remaining - 15'd1;
         lane      <= word_last ? 2'd0 : lane + 2'd1;
      end
   end

   // Word assembly. This clears on completion so the next byte can land in lane 0
   // in the very next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         asm_data <= 32'd0;
         asm_en   <= 4'd0;
      end else if (start_ok) begin
         asm_data <= 32'd0;
         asm_en   <= 4'd0;
      end else if (accept) begin
         if (word_last) begin
            asm_data <= 32'd0;
            asm_en   <= 4'd0;
         end else begin
            asm_data <= merged_data;
            asm_en   <= merged_en;
         end
      end
   end

   // Registered RAM write port. The strobe lasts one cycle after the completing byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_we    <= 4'd0;
         ram_wdata <= 32'd0;
         ram_waddr <= 12'd0;
      end else begin
         ram_we <= 4'd0;
         if (!start_ok && accept && word_last) begin
            ram_we    <= merged_en;
            ram_wdata <= merged_data;
            ram_waddr <= word_addr;
         end
      end
   end

   // Word address, advanced modulo 4096 after each write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_addr <= 12'd0;
      end else if (start_ok) begin
         word_addr <= start_addr;
      end else if (accept && word_last) begin
         word_addr <= word_addr + 12'd1;
      end
   end

   // Sticky wrap flag: set when the address steps past 0xFFF, cleared by the next start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrap <= 1'b0;
      end else if (start_ok) begin
         wrap <= 1'b0;
      end else if (accept && word_last && (word_addr == 12'hFFF)) begin
         wrap <= 1'b1;
      end
   end

endmodule
